// File: rtl/fifo_serial_tx_if.sv
// FIFO read port as seen by a serial consumer: empty flag and data in, pop strobe out.
// The master is the consumer that issues pops; the slave is the FIFO side.
interface fifo_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_read_data;
  logic              fifo_read_en;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    input  fifo_read_en
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops words from a FIFO and serializes each as start(0), DATA_W bits LSB first, stop(1).
// Consecutive frames run back to back: the next pop happens in the last STOP cycle.
module fifo_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   tx_en,
  fifo_serial_tx_if.master       fifo_rd,
  output logic                   tx_line,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                tx_line_q, tx_line_d;
  logic                frame_done_q, frame_done_d;
  logic                last_tick;
  logic                pop;

  assign last_tick = (tick_q == LAST_TICK);
  assign pop = tx_en && !fifo_rd.fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && last_tick));
  // The strobe is gated by reset so the FIFO never loses a word while we are held in reset.
  assign fifo_rd.fifo_read_en = pop && rstN;

  assign tx_line    = tx_line_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (pop) begin
          shift_d = fifo_rd.fifo_read_data;
          state_d = START;
        end
      end
      START: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
        if (last_tick) begin
          if (pop) begin
            shift_d = fifo_rd.fifo_read_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line and done flag are registered, so derive them from the state we are entering.
    case (state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
    frame_done_d = (state_d == STOP) && (tick_d == LAST_TICK);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      tx_line_q    <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      tx_line_q    <= tx_line_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
